// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fq_entry_t;

  localparam int FQ_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/fq_checker.sv
// Simulation-time property checks for the fetch queue occupancy and fetch handshake.
module fq_checker #(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input logic          clk,
  input logic          resetn,
  input logic [CW-1:0] count,
  input logic          in_valid1,
  input logic          in_valid2
);

  a_count_bound: assert property (@(posedge clk) disable iff (!resetn) count <= CW'(DEPTH))
    else $error("fetch queue occupancy above DEPTH");

  a_valid2_alone: assert property (@(posedge clk) disable iff (!resetn) !(in_valid2 && !in_valid1))
    else $warning("in_valid2 asserted without in_valid1; word ignored");

endmodule

// File: rtl/fq_mem.sv
// Fetch queue storage: two write ports at tail/tail+1, two async read ports at head/head+1.
// Contents are deliberately not reset; validity is tracked by the occupancy count in the top.
module fq_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we0,
  input  logic            we1,
  input  logic [AW-1:0]   waddr0,
  input  logic [AW-1:0]   waddr1,
  input  fq_entry_t       wdata0,
  input  fq_entry_t       wdata1,
  input  logic [AW-1:0]   raddr0,
  input  logic [AW-1:0]   raddr1,
  output fq_entry_t       rdata0,
  output fq_entry_t       rdata1
);

  fq_entry_t mem_r [DEPTH];

  // Write ports never collide: waddr1 is always waddr0+1 modulo DEPTH.
  always_ff @(posedge clk) begin
    if (we0) begin
      mem_r[waddr0] <= wdata0;
    end
    if (we1) begin
      mem_r[waddr1] <= wdata1;
    end
  end

  assign rdata0 = mem_r[raddr0];
  assign rdata1 = mem_r[raddr1];

endmodule

// File: rtl/inst_fetch_queue.sv
// Dual-in/dual-out instruction queue between I-cache fetch and the IF/ID register.
// Up to two words pushed and two retired per cycle; flush empties the queue.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          in_valid1,
  input  logic          in_valid2,
  input  logic [31:0]   in_addr1,
  input  logic [31:0]   in_addr2,
  input  logic [31:0]   in_data1,
  input  logic [31:0]   in_data2,
  output logic          in_ready,
  output logic          F_inst_ok1,
  output logic          F_inst_ok2,
  output logic [31:0]   F_addr1,
  output logic [31:0]   F_addr2,
  output logic [31:0]   F_data1,
  output logic [31:0]   F_data2,
  input  logic          D_ena1,
  input  logic          D_en2,
  output logic [AW:0]   count
);

  localparam int CW = AW + 1;

  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic [AW-1:0] head1_s;
  logic [AW-1:0] tail1_s;
  logic [1:0]    push_n_s;
  logic [1:0]    pop_req_s;
  logic [1:0]    pop_n_s;
  logic          we0_s;
  logic          we1_s;
  fq_entry_t     wdata0_s;
  fq_entry_t     wdata1_s;
  fq_entry_t     rdata0_s;
  fq_entry_t     rdata1_s;

  assign head1_s  = head_r + AW'(1);
  assign tail1_s  = tail_r + AW'(1);
  // Readiness uses the registered count only, so a same-cycle pop earns no credit.
  assign in_ready = (count_r <= CW'(DEPTH - 2));

  // Push/pop amounts; a retire request larger than the occupancy is clamped.
  always_comb begin
    push_n_s  = 2'd0;
    pop_req_s = 2'd0;
    pop_n_s   = 2'd0;
    if (in_ready && in_valid1) begin
      push_n_s = in_valid2 ? 2'd2 : 2'd1;
    end else begin
      push_n_s = 2'd0;
    end
    if (D_ena1) begin
      pop_req_s = D_en2 ? 2'd2 : 2'd1;
    end else begin
      pop_req_s = 2'd0;
    end
    if (CW'(pop_req_s) > count_r) begin
      pop_n_s = count_r[1:0];
    end else begin
      pop_n_s = pop_req_s;
    end
  end

  assign we0_s    = (push_n_s != 2'd0) && !flush;
  assign we1_s    = (push_n_s == 2'd2) && !flush;
  assign wdata0_s = '{addr: in_addr1, data: in_data1};
  assign wdata1_s = '{addr: in_addr2, data: in_data2};

  // Pointer and occupancy update; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_r + AW'(pop_n_s);
      tail_r  <= tail_r + AW'(push_n_s);
      count_r <= count_r + CW'(push_n_s) - CW'(pop_n_s);
    end
  end

  fq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk    (clk),
    .we0    (we0_s),
    .we1    (we1_s),
    .waddr0 (tail_r),
    .waddr1 (tail1_s),
    .wdata0 (wdata0_s),
    .wdata1 (wdata1_s),
    .raddr0 (head_r),
    .raddr1 (head1_s),
    .rdata0 (rdata0_s),
    .rdata1 (rdata1_s)
  );

  fq_checker #(.DEPTH(DEPTH)) u_chk (
    .clk       (clk),
    .resetn    (resetn),
    .count     (count_r),
    .in_valid1 (in_valid1),
    .in_valid2 (in_valid2)
  );

  assign count      = count_r;
  assign F_inst_ok1 = (count_r != CW'(0));
  assign F_inst_ok2 = (count_r >= CW'(2));
  assign F_addr1    = F_inst_ok1 ? rdata0_s.addr : 32'h0;
  assign F_data1    = F_inst_ok1 ? rdata0_s.data : 32'h0;
  assign F_addr2    = F_inst_ok2 ? rdata1_s.addr : 32'h0;
  assign F_data2    = F_inst_ok2 ? rdata1_s.data : 32'h0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed vector table plus flush/fill sequences.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid1, in_valid2, D_ena1, D_en2;
  logic [31:0] in_addr1, in_addr2, in_data1, in_data2;
  logic        in_ready, F_inst_ok1, F_inst_ok2;
  logic [31:0] F_addr1, F_addr2, F_data1, F_data2;
  logic [3:0]  count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(8)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid1(in_valid1), .in_valid2(in_valid2),
    .in_addr1(in_addr1), .in_addr2(in_addr2),
    .in_data1(in_data1), .in_data2(in_data2),
    .in_ready(in_ready), .F_inst_ok1(F_inst_ok1), .F_inst_ok2(F_inst_ok2),
    .F_addr1(F_addr1), .F_addr2(F_addr2), .F_data1(F_data1), .F_data2(F_data2),
    .D_ena1(D_ena1), .D_en2(D_en2), .count(count)
  );

  typedef struct {
    logic        rstn, fl, v1, v2, e1, e2;
    logic [31:0] a1, d1, a2, d2;
    logic [31:0] cnt;
    logic        rdy, ok1, ok2;
    logic [31:0] xa1, xd1, xa2, xd2;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] wa(input int n);
    if (n == 0) return 32'hBFC0_0000;
    else if (n == 1) return 32'hBFC0_0004;
    else return 32'h0000_1000 + 32'(n * 4);
  endfunction

  function automatic logic [31:0] wd(input int n);
    if (n == 0) return 32'h2401_0001;
    else if (n == 1) return 32'h2402_0002;
    else return 32'hA500_0000 + 32'(n);
  endfunction

  // p1/p2: pushed word numbers (-1 none); h1/h2: expected head words after the edge (-1 empty)
  task automatic add(input bit rstn, input bit fl, input int p1, input int p2,
                     input bit e1, input bit e2, input int cnt, input bit rdy,
                     input int h1, input int h2);
    vec_t v;
    v.rstn = rstn; v.fl = fl; v.e1 = e1; v.e2 = e2;
    v.v1 = (p1 >= 0); v.a1 = (p1 >= 0) ? wa(p1) : 32'h0; v.d1 = (p1 >= 0) ? wd(p1) : 32'h0;
    v.v2 = (p2 >= 0); v.a2 = (p2 >= 0) ? wa(p2) : 32'h0; v.d2 = (p2 >= 0) ? wd(p2) : 32'h0;
    v.cnt = 32'(cnt); v.rdy = rdy;
    v.ok1 = (h1 >= 0); v.xa1 = (h1 >= 0) ? wa(h1) : 32'h0; v.xd1 = (h1 >= 0) ? wd(h1) : 32'h0;
    v.ok2 = (h2 >= 0); v.xa2 = (h2 >= 0) ? wa(h2) : 32'h0; v.xd2 = (h2 >= 0) ? wd(h2) : 32'h0;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle();
    resetn = 1'b1; flush = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
    in_addr1 = 32'h0; in_addr2 = 32'h0; in_data1 = 32'h0; in_data2 = 32'h0;
    D_ena1 = 1'b0; D_en2 = 1'b0;
  endtask

  task automatic push(input int p1, input int p2);
    in_valid1 = 1'b1; in_addr1 = wa(p1); in_data1 = wd(p1);
    in_valid2 = (p2 >= 0);
    in_addr2 = (p2 >= 0) ? wa(p2) : 32'h0;
    in_data2 = (p2 >= 0) ? wd(p2) : 32'h0;
  endtask

  initial begin
    int pushes;
    idle();
    resetn = 1'b0;

    // reset
    add(0,0,-1,-1,0,0, 0,1,-1,-1);
    add(0,0,-1,-1,0,0, 0,1,-1,-1);
    // pair push then pair pop
    add(1,0, 0, 1,0,0, 2,1, 0, 1);
    add(1,0,-1,-1,1,1, 0,1,-1,-1);
    // partial issue, D_en2 alone, over-pop at count 1
    add(1,0, 2, 3,0,0, 2,1, 2, 3);
    add(1,0, 4, 5,0,0, 4,1, 2, 3);
    add(1,0,-1,-1,1,0, 3,1, 3, 4);
    add(1,0,-1,-1,0,1, 3,1, 3, 4);
    add(1,0,-1,-1,1,1, 1,1, 5,-1);
    add(1,0,-1,-1,1,1, 0,1,-1,-1);
    // move head/tail to 7
    add(1,0, 6,-1,0,0, 1,1, 6,-1);
    add(1,0,-1,-1,1,0, 0,1,-1,-1);
    // fill across 7->0, read pair straddling 7/0
    add(1,0, 7, 8,0,0, 2,1, 7, 8);
    add(1,0, 9,10,0,0, 4,1, 7, 8);
    add(1,0,11,12,0,0, 6,1, 7, 8);
    add(1,0,13,-1,0,0, 7,0, 7, 8);
    add(1,0,14,15,0,0, 7,0, 7, 8);
    add(1,0,14,15,1,0, 6,1, 8, 9);
    add(1,0,14,15,1,1, 6,1,10,11);
    add(1,0,16,17,1,1, 6,1,12,13);
    add(1,0,-1,-1,1,1, 4,1,14,15);
    add(1,0,-1,-1,1,1, 2,1,16,17);
    add(1,0,-1,-1,1,1, 0,1,-1,-1);
    // flush at count 5 with push and pop, then fresh push
    add(1,0,18,19,0,0, 2,1,18,19);
    add(1,0,20,21,0,0, 4,1,18,19);
    add(1,0,22,-1,0,0, 5,1,18,19);
    add(1,1,23,24,1,1, 0,1,-1,-1);
    add(1,0,25,26,0,0, 2,1,25,26);
    // reset beats push and pop
    add(0,0,27,28,1,1, 0,1,-1,-1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      resetn = vecs[i].rstn; flush = vecs[i].fl;
      in_valid1 = vecs[i].v1; in_addr1 = vecs[i].a1; in_data1 = vecs[i].d1;
      in_valid2 = vecs[i].v2; in_addr2 = vecs[i].a2; in_data2 = vecs[i].d2;
      D_ena1 = vecs[i].e1; D_en2 = vecs[i].e2;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.count", i), 32'(count), vecs[i].cnt);
      chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d.ok1", i), 32'(F_inst_ok1), 32'(vecs[i].ok1));
      chk($sformatf("v%0d.ok2", i), 32'(F_inst_ok2), 32'(vecs[i].ok2));
      chk($sformatf("v%0d.addr1", i), F_addr1, vecs[i].xa1);
      chk($sformatf("v%0d.data1", i), F_data1, vecs[i].xd1);
      chk($sformatf("v%0d.addr2", i), F_addr2, vecs[i].xa2);
      chk($sformatf("v%0d.data2", i), F_data2, vecs[i].xd2);
    end

    // flush cycle still shows pre-flush contents
    @(negedge clk); idle(); push(30, 31);
    @(negedge clk); idle(); push(32, -1);
    @(negedge clk); idle(); push(33, -1); flush = 1'b1; D_ena1 = 1'b1;
    #1;
    chk("flush_cycle.count", 32'(count), 32'd3);
    chk("flush_cycle.ok1", 32'(F_inst_ok1), 32'd1);
    chk("flush_cycle.addr1", F_addr1, wa(30));
    chk("flush_cycle.data2", F_data2, wd(31));
    @(posedge clk); #1;
    chk("after_flush.count", 32'(count), 32'd0);
    chk("after_flush.ok1", 32'(F_inst_ok1), 32'd0);
    @(negedge clk); idle(); push(34, -1);
    @(posedge clk); #1;
    chk("post_flush_push.addr1", F_addr1, wa(34));
    chk("post_flush_push.count", 32'(count), 32'd1);

    // fill with pairs until in_ready drops, bounded
    @(negedge clk); idle(); flush = 1'b1;
    @(posedge clk); #1;
    pushes = 0;
    for (int c = 0; c < 10 && in_ready; c++) begin
      @(negedge clk); idle(); push(40 + 2 * c, 41 + 2 * c);
      @(posedge clk); #1;
      pushes++;
    end
    chk("fill.pushes", 32'(pushes), 32'd4);
    chk("fill.count", 32'(count), 32'd8);
    chk("fill.in_ready", 32'(in_ready), 32'd0);
    chk("fill.addr1", F_addr1, wa(40));
    @(negedge clk); idle(); push(60, 61); D_ena1 = 1'b1;
    @(posedge clk); #1;
    chk("full_pop1.count", 32'(count), 32'd7);
    chk("full_pop1.in_ready", 32'(in_ready), 32'd0);
    chk("full_pop1.addr1", F_addr1, wa(41));
    chk("full_pop1.addr2", F_addr2, wa(42));

    @(negedge clk); idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
